// File: rtl/voice_alloc.sv
// Voice allocator: linear-scan key table that picks a voice for each MIDI
// note event and hands it to the velocity and envelope stages.
module voice_alloc #(
    parameter int VOICES  = 32,
    parameter int V_WIDTH = 5
) (
    input  logic               clk,
    input  logic               reset_reg,
    input  logic               evt_valid,
    output logic               evt_ready,
    input  logic               evt_is_on,
    input  logic [6:0]         evt_key,
    input  logic [7:0]         evt_vel,
    output logic               reg_note_on,
    output logic               reg_note_off,
    output logic [7:0]         reg_cur_vel_on,
    output logic [V_WIDTH-1:0] reg_cur_key_adr,
    output logic [6:0]         reg_cur_key,
    output logic [VOICES-1:0]  keys_on
);

    localparam logic [V_WIDTH-1:0] LAST_IDX = V_WIDTH'(VOICES - 1);
    localparam logic [V_WIDTH-1:0] IDX_ONE  = V_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        SETUP = 2'd2,
        ISSUE = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic               ready_reg;
    logic               cap_on_reg;
    logic [6:0]         cap_key_reg;
    logic [7:0]         cap_vel_reg;
    logic [V_WIDTH-1:0] scan_idx_reg;
    logic               match_found_reg;
    logic [V_WIDTH-1:0] match_idx_reg;
    logic               free_found_reg;
    logic [V_WIDTH-1:0] free_idx_reg;
    logic [V_WIDTH-1:0] steal_ptr_reg;

    logic [VOICES-1:0]      valid_vec;
    logic [VOICES-1:0][6:0] key_table;

    logic               accept;
    logic               scan_valid;
    logic [6:0]         scan_key;
    logic               hit_match;
    logic               hit_free;
    logic               scan_last;
    logic               match_any;
    logic               do_steal;
    logic [V_WIDTH-1:0] sel_idx;
    logic [V_WIDTH-1:0] steal_ptr_inc;

    assign accept     = evt_valid && ready_reg;
    assign evt_ready  = ready_reg;
    assign keys_on    = valid_vec;

    assign scan_valid = valid_vec[scan_idx_reg];
    assign scan_key   = key_table[scan_idx_reg];
    assign hit_match  = scan_valid && (scan_key == cap_key_reg);
    assign hit_free   = !scan_valid;
    assign scan_last  = (scan_idx_reg == LAST_IDX);
    assign match_any  = match_found_reg || hit_match;

    // Retrigger beats a free voice, which beats stealing.
    assign do_steal      = cap_on_reg && !match_found_reg && !free_found_reg;
    assign sel_idx       = match_found_reg ? match_idx_reg :
                           free_found_reg  ? free_idx_reg  : steal_ptr_reg;
    assign steal_ptr_inc = (steal_ptr_reg == LAST_IDX) ? '0 : steal_ptr_reg + IDX_ONE;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SCAN;
            SCAN: begin
                if (scan_last) begin
                    // An unmatched note-off has nothing to release.
                    if (!cap_on_reg && !match_any) state_next = IDLE;
                    else                           state_next = SETUP;
                end
            end
            SETUP:   state_next = ISSUE;
            ISSUE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_reg) begin
            state_reg <= IDLE;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next == IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_reg) begin
            cap_on_reg      <= 1'b0;
            cap_key_reg     <= '0;
            cap_vel_reg     <= '0;
            scan_idx_reg    <= '0;
            match_found_reg <= 1'b0;
            match_idx_reg   <= '0;
            free_found_reg  <= 1'b0;
            free_idx_reg    <= '0;
            steal_ptr_reg   <= '0;
            reg_note_on     <= 1'b0;
            reg_note_off    <= 1'b0;
            reg_cur_vel_on  <= '0;
            reg_cur_key_adr <= '0;
            reg_cur_key     <= '0;
        end else begin
            reg_note_on  <= 1'b0;
            reg_note_off <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        // Velocity zero on a note-on is a release.
                        cap_on_reg      <= evt_is_on && (evt_vel != 8'd0);
                        cap_key_reg     <= evt_key;
                        cap_vel_reg     <= evt_vel;
                        scan_idx_reg    <= '0;
                        match_found_reg <= 1'b0;
                        free_found_reg  <= 1'b0;
                    end
                end
                SCAN: begin
                    if (hit_match && !match_found_reg) begin
                        match_found_reg <= 1'b1;
                        match_idx_reg   <= scan_idx_reg;
                    end
                    if (hit_free && !free_found_reg) begin
                        free_found_reg <= 1'b1;
                        free_idx_reg   <= scan_idx_reg;
                    end
                    if (!scan_last) scan_idx_reg <= scan_idx_reg + IDX_ONE;
                end
                SETUP: begin
                    // Loaded a full cycle ahead of the strobe for the velocity stage.
                    reg_cur_key_adr <= sel_idx;
                    reg_cur_key     <= cap_key_reg;
                    if (cap_on_reg) reg_cur_vel_on <= cap_vel_reg;
                    if (do_steal)   steal_ptr_reg  <= steal_ptr_inc;
                end
                ISSUE: begin
                    if (cap_on_reg) reg_note_on  <= 1'b1;
                    else            reg_note_off <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Per-voice key/valid slot, written only on the issue cycle of its index.
    genvar gi;
    generate
        for (gi = 0; gi < VOICES; gi++) begin : g_slot
            logic       slot_valid_reg;
            logic [6:0] slot_key_reg;

            always_ff @(posedge clk) begin
                if (reset_reg) begin
                    slot_valid_reg <= 1'b0;
                    slot_key_reg   <= '0;
                end else if (state_reg == ISSUE && reg_cur_key_adr == V_WIDTH'(gi)) begin
                    slot_valid_reg <= cap_on_reg;
                    if (cap_on_reg) slot_key_reg <= cap_key_reg;
                end
            end

            assign valid_vec[gi] = slot_valid_reg;
            assign key_table[gi] = slot_key_reg;
        end
    endgenerate

endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc: allocation, release, retrigger, steal,
// back-pressure and mid-scan reset.
module tb_voice_alloc;

    logic        clk;
    logic        reset_reg;
    logic        evt_valid;
    logic        evt_ready;
    logic        evt_is_on;
    logic [6:0]  evt_key;
    logic [7:0]  evt_vel;
    logic        reg_note_on;
    logic        reg_note_off;
    logic [7:0]  reg_cur_vel_on;
    logic [4:0]  reg_cur_key_adr;
    logic [6:0]  reg_cur_key;
    logic [31:0] keys_on;

    int n_checks = 0;
    int n_fails  = 0;

    voice_alloc #(.VOICES(32), .V_WIDTH(5)) dut (
        .clk             (clk),
        .reset_reg       (reset_reg),
        .evt_valid       (evt_valid),
        .evt_ready       (evt_ready),
        .evt_is_on       (evt_is_on),
        .evt_key         (evt_key),
        .evt_vel         (evt_vel),
        .reg_note_on     (reg_note_on),
        .reg_note_off    (reg_note_off),
        .reg_cur_vel_on  (reg_cur_vel_on),
        .reg_cur_key_adr (reg_cur_key_adr),
        .reg_cur_key     (reg_cur_key),
        .keys_on         (keys_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        reset_reg = 1'b1;
        evt_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_reg = 1'b0;
    endtask

    // Sends one event, then follows it until evt_ready returns, noting any strobe.
    task automatic do_event(input logic on, input logic [6:0] key, input logic [7:0] vel,
                            output int lat, output int rdy_lat,
                            output logic saw_on, output logic saw_off,
                            output logic [4:0] adr, output logic [4:0] adr_pre,
                            output logic [7:0] vel_o, output logic [6:0] key_o);
        int guard;
        logic [4:0] prev;
        lat = 0; rdy_lat = 0; saw_on = 0; saw_off = 0;
        adr = '0; adr_pre = '0; vel_o = '0; key_o = '0;
        @(negedge clk);
        guard = 0;
        while (evt_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (evt_ready !== 1'b1) begin
            n_checks++; n_fails++;
            $display("FAIL ready_wait: evt_ready=%b, required 1 within 100 cycles", evt_ready);
            return;
        end
        evt_valid = 1'b1; evt_is_on = on; evt_key = key; evt_vel = vel;
        @(posedge clk);
        #1 evt_valid = 1'b0;
        prev = reg_cur_key_adr;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            if ((reg_note_on || reg_note_off) && lat == 0) begin
                lat = k; saw_on = reg_note_on; saw_off = reg_note_off;
                adr = reg_cur_key_adr; adr_pre = prev; vel_o = reg_cur_vel_on; key_o = reg_cur_key;
            end
            prev = reg_cur_key_adr;
            if (evt_ready === 1'b1) begin
                rdy_lat = k;
                break;
            end
        end
        if (rdy_lat == 0) begin
            n_checks++; n_fails++;
            $display("FAIL event_done: evt_ready never returned within 80 cycles (key %0d)", key);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_reg = 1'b1; evt_valid = 1'b0; evt_is_on = 1'b0; evt_key = '0; evt_vel = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({evt_ready, reg_note_on, reg_note_off} !== 3'b000) begin
            n_fails++;
            $display("FAIL reset_ctrl: ready/on/off=%b, required 000", {evt_ready, reg_note_on, reg_note_off});
        end
        n_checks++;
        if (keys_on !== 32'h0 || reg_cur_key_adr !== 5'd0 || reg_cur_vel_on !== 8'd0 || reg_cur_key !== 7'd0) begin
            n_fails++;
            $display("FAIL reset_data: keys_on=%h adr=%0d vel=%0d key=%0d, required all 0",
                     keys_on, reg_cur_key_adr, reg_cur_vel_on, reg_cur_key);
        end
        @(negedge clk);
        reset_reg = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (evt_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_ready: evt_ready=%b, required 1 after reset release", evt_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_first_note();
        int lat, rl; logic so, sf; logic [4:0] a, ap; logic [7:0] v; logic [6:0] k;
        do_event(1'b1, 7'd60, 8'd100, lat, rl, so, sf, a, ap, v, k);
        n_checks++;
        if (lat !== 34 || so !== 1'b1 || sf !== 1'b0) begin
            n_fails++;
            $display("FAIL first_strobe: lat=%0d on=%b off=%b, required 34 1 0", lat, so, sf);
        end
        n_checks++;
        if (a !== 5'd0 || ap !== 5'd0 || v !== 8'd100 || k !== 7'd60) begin
            n_fails++;
            $display("FAIL first_fields: adr=%0d pre=%0d vel=%0d key=%0d, required 0 0 100 60", a, ap, v, k);
        end
        n_checks++;
        if (keys_on !== 32'h1) begin
            n_fails++;
            $display("FAIL first_keys_on: keys_on=%h, required 00000001", keys_on);
        end
        $display("test_first_note: lat=%0d adr=%0d vel=%0d", lat, a, v);
    endtask

    task automatic test_alloc_release();
        int lat, rl; logic so, sf; logic [4:0] a, ap; logic [7:0] v; logic [6:0] k;
        logic [6:0] keys [3];
        keys[0] = 7'd60; keys[1] = 7'd62; keys[2] = 7'd64;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            do_event(1'b1, keys[i], 8'd80, lat, rl, so, sf, a, ap, v, k);
            n_checks++;
            if (a !== 5'(i) || so !== 1'b1 || ap !== 5'(i)) begin
                n_fails++;
                $display("FAIL alloc_%0d: adr=%0d pre=%0d on=%b, required %0d %0d 1", i, a, ap, so, i, i);
            end
            $display("alloc key %0d -> voice %0d", keys[i], a);
        end
        do_event(1'b0, 7'd62, 8'd0, lat, rl, so, sf, a, ap, v, k);
        n_checks++;
        if (sf !== 1'b1 || so !== 1'b0 || a !== 5'd1 || lat !== 34) begin
            n_fails++;
            $display("FAIL release_62: off=%b on=%b adr=%0d lat=%0d, required 1 0 1 34", sf, so, a, lat);
        end
        n_checks++;
        if (keys_on !== 32'h5) begin
            n_fails++;
            $display("FAIL release_keys_on: keys_on=%h, required 00000005", keys_on);
        end
        do_event(1'b1, 7'd70, 8'd33, lat, rl, so, sf, a, ap, v, k);
        n_checks++;
        if (a !== 5'd1 || so !== 1'b1 || v !== 8'd33 || keys_on !== 32'h7) begin
            n_fails++;
            $display("FAIL reuse_voice: adr=%0d on=%b vel=%0d keys_on=%h, required 1 1 33 00000007",
                     a, so, v, keys_on);
        end
        $display("test_alloc_release: key 70 -> voice %0d", a);
    endtask

    task automatic test_retrigger();
        int lat, rl; logic so, sf; logic [4:0] a, ap; logic [7:0] v; logic [6:0] k;
        apply_reset();
        do_event(1'b1, 7'd60, 8'd50, lat, rl, so, sf, a, ap, v, k);
        n_checks++;
        if (a !== 5'd0 || v !== 8'd50 || so !== 1'b1) begin
            n_fails++;
            $display("FAIL retrig_first: adr=%0d vel=%0d on=%b, required 0 50 1", a, v, so);
        end
        do_event(1'b1, 7'd60, 8'd90, lat, rl, so, sf, a, ap, v, k);
        n_checks++;
        if (a !== 5'd0 || v !== 8'd90 || so !== 1'b1 || sf !== 1'b0) begin
            n_fails++;
            $display("FAIL retrig_second: adr=%0d vel=%0d on=%b off=%b, required 0 90 1 0", a, v, so, sf);
        end
        n_checks++;
        if (keys_on !== 32'h1) begin
            n_fails++;
            $display("FAIL retrig_keys_on: keys_on=%h, required 00000001", keys_on);
        end
        $display("test_retrigger: adr=%0d vel=%0d", a, v);
    endtask

    task automatic test_steal();
        int lat, rl; logic so, sf; logic [4:0] a, ap; logic [7:0] v; logic [6:0] k;
        int any_off;
        apply_reset();
        any_off = 0;
        for (int i = 0; i < 32; i++) begin
            do_event(1'b1, 7'(i), 8'd64, lat, rl, so, sf, a, ap, v, k);
            n_checks++;
            if (a !== 5'(i) || so !== 1'b1) begin
                n_fails++;
                $display("FAIL fill_%0d: adr=%0d on=%b, required %0d 1", i, a, so, i);
            end
        end
        n_checks++;
        if (keys_on !== 32'hffff_ffff) begin
            n_fails++;
            $display("FAIL fill_keys_on: keys_on=%h, required ffffffff", keys_on);
        end
        // Steal keys 40..72 never collide with held keys; pointer walks 0..31 then wraps.
        for (int j = 0; j <= 32; j++) begin
            do_event(1'b1, 7'(40 + j), 8'd70, lat, rl, so, sf, a, ap, v, k);
            if (sf) any_off++;
            n_checks++;
            if (a !== 5'(j % 32) || so !== 1'b1 || k !== 7'(40 + j)) begin
                n_fails++;
                $display("FAIL steal_%0d: adr=%0d on=%b key=%0d, required %0d 1 %0d",
                         j, a, so, k, j % 32, 40 + j);
            end
            if (j < 3 || j == 32) $display("steal key %0d -> voice %0d", 40 + j, a);
        end
        n_checks++;
        if (any_off !== 0 || keys_on !== 32'hffff_ffff) begin
            n_fails++;
            $display("FAIL steal_no_off: off pulses=%0d keys_on=%h, required 0 ffffffff", any_off, keys_on);
        end
    endtask

    task automatic test_note_off_cases();
        int lat, rl; logic so, sf; logic [4:0] a, ap; logic [7:0] v; logic [6:0] k;
        apply_reset();
        do_event(1'b1, 7'd60, 8'd100, lat, rl, so, sf, a, ap, v, k);
        do_event(1'b1, 7'd61, 8'd100, lat, rl, so, sf, a, ap, v, k);
        do_event(1'b0, 7'd99, 8'd0, lat, rl, so, sf, a, ap, v, k);
        n_checks++;
        if (lat !== 0 || rl !== 32 || keys_on !== 32'h3) begin
            n_fails++;
            $display("FAIL unheld_off: strobe_lat=%0d ready_lat=%0d keys_on=%h, required 0 32 00000003",
                     lat, rl, keys_on);
        end
        $display("note-off key 99: strobe_lat=%0d ready_lat=%0d", lat, rl);
        do_event(1'b1, 7'd61, 8'd0, lat, rl, so, sf, a, ap, v, k);
        n_checks++;
        if (sf !== 1'b1 || so !== 1'b0 || a !== 5'd1 || keys_on !== 32'h1 || v !== 8'd100) begin
            n_fails++;
            $display("FAIL vel0_off: off=%b on=%b adr=%0d keys_on=%h vel=%0d, required 1 0 1 00000001 100",
                     sf, so, a, keys_on, v);
        end
        do_event(1'b1, 7'd60, 8'd0, lat, rl, so, sf, a, ap, v, k);
        n_checks++;
        if (sf !== 1'b1 || a !== 5'd0 || keys_on !== 32'h0) begin
            n_fails++;
            $display("FAIL vel0_off_60: off=%b adr=%0d keys_on=%h, required 1 0 00000000", sf, a, keys_on);
        end
        $display("note-on vel 0 key 60: off=%b adr=%0d", sf, a);
    endtask

    task automatic test_back_to_back();
        int first_k, second_k, strobes;
        logic [4:0] first_a, second_a;
        logic ready_at_35;
        int lat, rl; logic so, sf; logic [4:0] a, ap; logic [7:0] v; logic [6:0] k;
        apply_reset();
        @(negedge clk);
        first_k = 0; second_k = 0; first_a = '0; second_a = '0; ready_at_35 = 1'b0;
        evt_valid = 1'b1; evt_is_on = 1'b1; evt_key = 7'd60; evt_vel = 8'd20;
        @(posedge clk);
        #1 evt_key = 7'd62;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk);
            #1;
            if (reg_note_on && first_k == 0) begin
                first_k = c; first_a = reg_cur_key_adr;
            end else if (reg_note_on && second_k == 0) begin
                second_k = c; second_a = reg_cur_key_adr;
            end
            if (c == 35) begin
                ready_at_35 = evt_ready;
                evt_valid = 1'b0;
            end
        end
        n_checks++;
        if (first_k !== 34 || first_a !== 5'd0) begin
            n_fails++;
            $display("FAIL held_first: lat=%0d adr=%0d, required 34 0", first_k, first_a);
        end
        n_checks++;
        if (second_k !== 69 || second_a !== 5'd1 || ready_at_35 !== 1'b0 || keys_on !== 32'h3) begin
            n_fails++;
            $display("FAIL held_second: lat=%0d adr=%0d ready@35=%b keys_on=%h, required 69 1 0 00000003",
                     second_k, second_a, ready_at_35, keys_on);
        end
        $display("held valid: strobes at %0d (voice %0d) and %0d (voice %0d)", first_k, first_a, second_k, second_a);

        // Reset in the middle of a scan must abort the event and clear the table.
        @(negedge clk);
        evt_valid = 1'b1; evt_is_on = 1'b1; evt_key = 7'd70; evt_vel = 8'd55;
        @(posedge clk);
        #1 evt_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset_reg = 1'b1;
        @(negedge clk);
        reset_reg = 1'b0;
        strobes = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (reg_note_on || reg_note_off) strobes++;
        end
        n_checks++;
        if (strobes !== 0 || keys_on !== 32'h0 || evt_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL abort_scan: strobes=%0d keys_on=%h ready=%b, required 0 00000000 1",
                     strobes, keys_on, evt_ready);
        end
        do_event(1'b1, 7'd80, 8'd77, lat, rl, so, sf, a, ap, v, k);
        n_checks++;
        if (a !== 5'd0 || so !== 1'b1 || lat !== 34 || keys_on !== 32'h1) begin
            n_fails++;
            $display("FAIL after_abort: adr=%0d on=%b lat=%0d keys_on=%h, required 0 1 34 00000001",
                     a, so, lat, keys_on);
        end
        $display("after abort: key 80 -> voice %0d", a);
    endtask

    initial begin
        reset_reg = 1'b1;
        evt_valid = 1'b0;
        evt_is_on = 1'b0;
        evt_key   = '0;
        evt_vel   = '0;
        test_reset();
        test_first_note();
        test_alloc_release();
        test_retrigger();
        test_steal();
        test_note_off_cases();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/voice_alloc.md
Name: voice_alloc

Overview:
- Voice allocator; sits directly upstream of the per-voice velocity store.
- Accepts decoded MIDI note-on/note-off events and chooses a voice for each one.
- Drives reg_note_on, reg_cur_vel_on and reg_cur_key_adr for the velocity stage, plus a note-off strobe and a per-voice gate vector for the envelope stage.
- Sequential linear scan of a per-voice key table, one voice per clock.

Parameters:
VOICES, 32, number of synth voices
V_WIDTH, 5, voice index width, clog2(VOICES)

Ports:
clk  in  1  system clock
reset_reg  in  1  synchronous, active-high reset
evt_valid  in  1  event present
evt_ready  out  1  allocator can accept an event
evt_is_on  in  1  1 = note-on, 0 = note-off
evt_key  in  7  MIDI key number
evt_vel  in  8  velocity (MIDI 0..127; 8'hff allowed)
reg_note_on  out  1  one-cycle note-on strobe
reg_note_off  out  1  one-cycle note-off strobe
reg_cur_vel_on  out  8  velocity for the chosen voice
reg_cur_key_adr  out  V_WIDTH  chosen voice index
reg_cur_key  out  7  key assigned to reg_cur_key_adr
keys_on  out  VOICES  per-voice gate, bit v = voice v held

Behaviour:
- Reset (reset_reg high at clk edge):
  - All outputs go to 0, including evt_ready.
  - Key table and valid bits are cleared.
  - steal_ptr goes to 0.
  - FSM goes to IDLE.
  - evt_ready is 1 on the first cycle after reset deasserts.
  - Reset mid-scan aborts the event. No strobe is issued.
- Handshake:
  - An event is accepted on a clk edge when evt_valid && evt_ready.
  - evt_ready = (state == IDLE).
  - evt_is_on, evt_key and evt_vel are captured at acceptance.
  - evt_valid while not ready is not consumed; the upstream holds it.
- A note-on with evt_vel == 0 is treated as a note-off (MIDI convention).
- FSM states: IDLE -> SCAN -> SETUP -> ISSUE -> IDLE. SCAN may instead go directly to IDLE.
  - SCAN:
    - Examines voice i = 0..VOICES-1, one per cycle, for VOICES cycles.
    - Records match_idx: the first valid voice whose key equals the captured key.
    - Records free_idx: the first voice with valid == 0.
  - Note-on selection, in priority order:
    1. match_idx (retrigger, same voice).
    2. Else free_idx.
    3. Else steal_ptr. steal_ptr then increments modulo VOICES. Wrap from VOICES-1 to 0.
  - Note-off with no match: SCAN -> IDLE. No strobe, no table change.
  - SETUP:
    - reg_cur_key_adr, reg_cur_key and reg_cur_vel_on (note-on only) are loaded.
    - The velocity stage registers on the reg_note_on edge, so these must be stable one full cycle before the strobe.
  - ISSUE:
    - Note-on: reg_note_on = 1 for exactly one cycle. Table entry is set to {valid = 1, key}. keys_on[idx] is set.
    - Note-off: reg_note_off = 1 for one cycle. valid[idx] and keys_on[idx] are cleared.
  - reg_cur_* hold their values until the next SETUP.
- Latency, acceptance edge to strobe: VOICES + 2 cycles (34 at default). Peak rate is one event per VOICES + 3 cycles.
- reg_note_on and reg_note_off are never high in the same cycle.
- A retrigger on a held voice strobes reg_note_on again on the same index; keys_on stays 1.
- Steal: the voice is reassigned in place. No reg_note_off is issued for the victim.
- Width rules: every index compare and increment is V_WIDTH bits. VOICES need not be a power of two; the increment wraps explicitly at VOICES-1.

Test Plan:
1. Reset then note-on key 60, vel 100 -> evt_ready 1 on the cycle after reset. Strobe 34 cycles after acceptance. reg_cur_key_adr 0, reg_cur_vel_on 100, keys_on = 1.
2. Note-on keys 60, 62, 64 -> voices 0, 1, 2. Then note-off key 62 -> reg_note_off with adr 1, keys_on = 3'b101. Then note-on key 70 -> voice 1.
3. Note-on key 60 twice, vel 50 then vel 90 -> both strobes on adr 0. Second reg_cur_vel_on = 90. Only keys_on[0] set.
4. Fill 32 voices, then note-ons keys 100, 101 -> steal voices 0, 1. steal_ptr = 2. No reg_note_off pulses.
5. Note-off key 99 (unheld), and note-on key 60 vel 0 while 60 held -> first: no strobe, back to IDLE after 32 scan cycles. Second: reg_note_off with key 60's voice.
6. evt_valid held high during a scan -> not accepted until evt_ready. Reset asserted mid-SCAN -> no strobe, keys_on = 0, next event allocates voice 0.
